div_bcd_out: RTL and testbench

Downstream stage of the 16-bit divider (div_16bit). Captures one quotient/remainder pair (result, odd) through a valid/ready handshake. Converts both values to packed BCD with an iterative double-dabble, one bit per clock. Presents the two BCD words to the display/reporting logic through a second valid/ready handshake.

---
 rtl/div_bcd_out_if.sv | 27 ++
 rtl/div_bcd_out.sv | 134 +++++++++++++
 tb/tb_div_bcd_out.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_bcd_out_if.sv
// Handshake bundle between div_16bit, the BCD converter and the display/reporting logic.
interface div_bcd_out_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      result;
  logic [WIDTH-1:0]      odd;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  busy;
  logic [DIGITS-1:0]     q_lz;
  logic [DIGITS-1:0]     r_lz;

  modport master (
    output in_valid, result, odd, out_ready,
    input  in_ready, out_valid, q_bcd, r_bcd, busy, q_lz, r_lz
  );

  modport slave (
    input  in_valid, result, odd, out_ready,
    output in_ready, out_valid, q_bcd, r_bcd, busy, q_lz, r_lz
  );
endinterface

// File: rtl/div_bcd_out.sv
// Quotient/remainder to packed BCD via double-dabble, one bit per clock, both channels in parallel.
// Optional leading-zero digit masks are built when DIV_BCD_LZ_BLANK_EN is defined.
module div_bcd_out #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic            clk,
  input  logic            rst,
  div_bcd_out_if.slave    bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic               load;
  logic               last_shift;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   q_bin, r_bin;
  logic [BCD_W-1:0]   q_acc, r_acc;
  logic [BCD_W-1:0]   q_adj, r_adj;
  logic [BCD_W-1:0]   q_acc_nxt, r_acc_nxt;
  logic [BCD_W-1:0]   q_bcd_r, r_bcd_r;

  // Digits are at most 9, so +3 never leaves the nibble and no inter-digit carry exists.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (res[4*d +: 4] >= 4'd5)
        res[4*d +: 4] = res[4*d +: 4] + 4'd3;
    end
    return res;
  endfunction

  assign last_shift = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == SHIFT);

  // Stage boundary: adjust then shift {acc, bin} left, binary MSB into acc LSB.
  assign q_adj     = dabble_adj(q_acc);
  assign r_adj     = dabble_adj(r_acc);
  assign q_acc_nxt = {q_adj[BCD_W-2:0], q_bin[WIDTH-1]};
  assign r_acc_nxt = {r_adj[BCD_W-2:0], r_bin[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      q_bin   <= '0;
      r_bin   <= '0;
      q_acc   <= '0;
      r_acc   <= '0;
      q_bcd_r <= '0;
      r_bcd_r <= '0;
    end else if (load) begin
      cnt   <= '0;
      q_bin <= bus.result;
      r_bin <= bus.odd;
      q_acc <= '0;
      r_acc <= '0;
    end else if (state == SHIFT) begin
      cnt   <= cnt + CNT_W'(1);
      q_bin <= {q_bin[WIDTH-2:0], 1'b0};
      r_bin <= {r_bin[WIDTH-2:0], 1'b0};
      q_acc <= q_acc_nxt;
      r_acc <= r_acc_nxt;
      if (last_shift) begin
        q_bcd_r <= q_acc_nxt;
        r_bcd_r <= r_acc_nxt;
      end
    end
  end

  assign bus.q_bcd = q_bcd_r;
  assign bus.r_bcd = r_bcd_r;

`ifdef DIV_BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] q_lz_r, r_lz_r;

  // Digit 0 never blanks so a zero value still displays one digit.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [BCD_W-1:0] bcd);
    logic [DIGITS-1:0] m;
    logic              z;
    m = '0;
    z = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      z    = z & (bcd[4*d +: 4] == 4'd0);
      m[d] = z;
    end
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      q_lz_r <= '0;
      r_lz_r <= '0;
    end else if (state == SHIFT && last_shift) begin
      q_lz_r <= lz_mask(q_acc_nxt);
      r_lz_r <= lz_mask(r_acc_nxt);
    end
  end

  assign bus.q_lz = q_lz_r;
  assign bus.r_lz = r_lz_r;
`else
  assign bus.q_lz = '0;
  assign bus.r_lz = '0;
`endif

endmodule

// File: tb/tb_div_bcd_out.sv
// Directed bench for div_bcd_out: latency, boundary values, backpressure, reset abort, masks, back-to-back.
module tb_div_bcd_out;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  div_bcd_out_if #(.WIDTH(16), .DIGITS(5)) bus ();

  div_bcd_out #(.WIDTH(16), .DIGITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair, lets it be accepted and returns edges until out_valid (-1 on timeout).
  task automatic convert(input logic [15:0] a, input logic [15:0] b, output int lat);
    bus.result   = a;
    bus.odd      = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.result    = 16'd0;
    bus.odd       = 16'd0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_flags got out_valid=%0b busy=%0b want 0 0", bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.q_bcd !== 20'h0 || bus.r_bcd !== 20'h0 || bus.q_lz !== 5'b0 || bus.r_lz !== 5'b0) begin
      errors++; $display("FAIL rst_data got q=%h r=%h qlz=%b rlz=%b want zeros", bus.q_bcd, bus.r_bcd, bus.q_lz, bus.r_lz);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    bus.out_ready = 1'b1;
    bus.result    = 16'd1234;
    bus.odd       = 16'd7;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy got busy=%0b in_ready=%0b want 1 0", bus.busy, bus.in_ready);
    end
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    lat--;
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", lat); end
    checks++;
    if (bus.q_bcd !== 20'h01234 || bus.r_bcd !== 20'h00007) begin
      errors++; $display("FAIL basic_value got q=%h r=%h want 01234 00007", bus.q_bcd, bus.r_bcd);
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_busy got %0b want 0", bus.busy); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_return got out_valid=%0b in_ready=%0b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_max_zero();
    int lat;
    bus.out_ready = 1'b1;
    convert(16'd65535, 16'd65535, lat);
    checks++;
    if (lat !== 16 || bus.q_bcd !== 20'h65535 || bus.r_bcd !== 20'h65535) begin
      errors++; $display("FAIL max_value got lat=%0d q=%h r=%h want 16 65535 65535", lat, bus.q_bcd, bus.r_bcd);
    end
    tick();
    convert(16'd0, 16'd0, lat);
    checks++;
    if (lat !== 16 || bus.q_bcd !== 20'h00000 || bus.r_bcd !== 20'h00000) begin
      errors++; $display("FAIL zero_value got lat=%0d q=%h r=%h want 16 00000 00000", lat, bus.q_bcd, bus.r_bcd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    bus.out_ready = 1'b0;
    convert(16'd999, 16'd3, lat);
    checks++;
    if (lat !== 16 || bus.q_bcd !== 20'h00999 || bus.r_bcd !== 20'h00003) begin
      errors++; $display("FAIL bp_value got lat=%0d q=%h r=%h want 16 00999 00003", lat, bus.q_bcd, bus.r_bcd);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.result   = 16'd123;
      bus.odd      = 16'd45;
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.q_bcd !== 20'h00999 || bus.r_bcd !== 20'h00003)
        bad++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.q_bcd !== 20'h00999) begin
      errors++; $display("FAIL bp_release got out_valid=%0b in_ready=%0b busy=%0b q=%h want 0 1 0 00999",
                         bus.out_valid, bus.in_ready, bus.busy, bus.q_bcd);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.out_ready = 1'b1;
    bus.result    = 16'd4321;
    bus.odd       = 16'd11;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_state got out_valid=%0b busy=%0b in_ready=%0b want 0 0 1",
                         bus.out_valid, bus.busy, bus.in_ready);
    end
    checks++;
    if (bus.q_bcd !== 20'h0 || bus.r_bcd !== 20'h0) begin
      errors++; $display("FAIL abort_data got q=%h r=%h want 00000 00000", bus.q_bcd, bus.r_bcd);
    end
    convert(16'd50, 16'd9, lat);
    checks++;
    if (lat !== 16 || bus.q_bcd !== 20'h00050 || bus.r_bcd !== 20'h00009) begin
      errors++; $display("FAIL abort_next got lat=%0d q=%h r=%h want 16 00050 00009", lat, bus.q_bcd, bus.r_bcd);
    end
    tick();
  endtask

  task automatic test_lz();
    int lat;
    logic [4:0] exp_q, exp_r;
`ifdef DIV_BCD_LZ_BLANK_EN
    exp_q = 5'b11100;
    exp_r = 5'b11110;
`else
    exp_q = 5'b00000;
    exp_r = 5'b00000;
`endif
    bus.out_ready = 1'b1;
    convert(16'd42, 16'd0, lat);
    checks++;
    if (bus.q_bcd !== 20'h00042 || bus.r_bcd !== 20'h00000) begin
      errors++; $display("FAIL lz_value got q=%h r=%h want 00042 00000", bus.q_bcd, bus.r_bcd);
    end
    checks++;
    if (bus.q_lz !== exp_q || bus.r_lz !== exp_r) begin
      errors++; $display("FAIL lz_mask got q_lz=%b r_lz=%b want %b %b", bus.q_lz, bus.r_lz, exp_q, exp_r);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [4];
    logic [15:0] pb [4];
    logic [19:0] eq [4];
    logic [19:0] er [4];
    int acc, nout, cyc, last;
    logic fire;
    pa[0] = 16'd1;     pb[0] = 16'd2;     eq[0] = 20'h00001; er[0] = 20'h00002;
    pa[1] = 16'd10000; pb[1] = 16'd9999;  eq[1] = 20'h10000; er[1] = 20'h09999;
    pa[2] = 16'd4096;  pb[2] = 16'd255;   eq[2] = 20'h04096; er[2] = 20'h00255;
    pa[3] = 16'd31415; pb[3] = 16'd27182; eq[3] = 20'h31415; er[3] = 20'h27182;
    acc = 0; nout = 0; cyc = 0; last = 0;
    bus.out_ready = 1'b1;
    bus.result    = pa[0];
    bus.odd       = pb[0];
    bus.in_valid  = 1'b1;
    while (nout < 4 && cyc < 300) begin
      fire = bus.in_valid & bus.in_ready;
      tick();
      cyc++;
      if (fire) begin
        acc++;
        if (acc < 4) begin
          bus.result = pa[acc];
          bus.odd    = pb[acc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (bus.q_bcd !== eq[nout] || bus.r_bcd !== er[nout]) begin
          errors++; $display("FAIL b2b_value[%0d] got q=%h r=%h want %h %h", nout, bus.q_bcd, bus.r_bcd, eq[nout], er[nout]);
        end
        if (nout > 0) begin
          checks++;
          if (cyc - last !== 18) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 18", nout, cyc - last); end
        end
        last = cyc;
        nout++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (nout !== 4 || acc !== 4) begin
      errors++; $display("FAIL b2b_count got outputs=%0d accepts=%0d want 4 4", nout, acc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_zero();
    test_backpressure();
    test_reset_mid();
    test_lz();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
